// File: rtl/ram_rd_pkg.sv
// Shared definitions for the RAM burst reader.
// Holds the FSM state type; the enum members S_IDLE, S_STREAM and S_FINISH
// are the state constants used by the reader and visible to anyone importing
// this package.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/ASYNC_RAM.sv
// Simple single-port-write, asynchronous-read memory model.
// Ports:
//   clk      - write clock
//   we       - write enable, sampled on the rising edge
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   q        - read data, combinational from rd_addr
module ASYNC_RAM #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] q
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign q = mem[rd_addr];

endmodule

// File: rtl/ram_burst_reader.sv
// Burst reader: streams len consecutive words out of an asynchronous-read
// RAM, starting at base_addr and wrapping modulo 2^AWIDTH, over a
// valid/ready stream interface.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; mem_addr follows base_addr
// S_STREAM | a word is held in out_data; advance on each handshake
// S_FINISH | one-cycle completion, done=1
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - burst request, sampled in S_IDLE only
//   base_addr   - first word address, captured with start
//   len         - word count (0..2^AWIDTH), captured with start
//   mem_addr    - read address to the RAM
//   mem_q       - combinational RAM read data for mem_addr
//   out_data    - stream data (registered)
//   out_valid   - stream valid (registered)
//   out_ready   - stream ready from the consumer
//   busy        - high while streaming
//   done        - one-cycle pulse at burst completion
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_q,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
  localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);

  state_t state, state_nxt;

  // addr_r: address of the next word to load; cnt_r: words still to load
  // after the one currently held in out_data.
  logic [AWIDTH-1:0] addr_r;
  logic [AWIDTH:0]   cnt_r;

  logic handshake;
  logic load_first;
  logic load_next;
  logic last_hs;

  assign handshake = out_valid & out_ready;

  // In idle the RAM already looks at base_addr so the first word can be
  // captured on the same edge that accepts start.
  assign mem_addr = (state == S_IDLE) ? base_addr : addr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    last_hs    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt  = S_STREAM;
            load_first = 1'b1;
          end else begin
            state_nxt = S_FINISH;
          end
        end
      end
      S_STREAM: begin
        busy = 1'b1;
        if (handshake) begin
          if (cnt_r != '0) begin
            load_next = 1'b1;
          end else begin
            last_hs   = 1'b1;
            state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      addr_r    <= '0;
      cnt_r     <= '0;
    end else if (load_first) begin
      out_data  <= mem_q;
      out_valid <= 1'b1;
      addr_r    <= base_addr + ADDR_ONE;
      cnt_r     <= len - CNT_ONE;
    end else if (load_next) begin
      out_data  <= mem_q;
      addr_r    <= addr_r + ADDR_ONE;
      cnt_r     <= cnt_r - CNT_ONE;
    end else if (last_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] len = '0;
  logic [7:0] mem_addr;
  logic [7:0] mem_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       we = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ASYNC_RAM #(.DWIDTH(8), .AWIDTH(8)) u_ram (
    .clk(clk), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(mem_addr), .q(mem_q)
  );

  ram_burst_reader #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .mem_addr(mem_addr), .mem_q(mem_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; base_addr = 8'h00; len = 9'd3;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      we = 1'b1; wr_addr = 8'(i); wr_data = 8'(i) ^ 8'hA5;
      tick();
    end
    we = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    base_addr = 8'h10; len = 9'd4; out_ready = 1'b1; start = 1'b1;
    #1;
    n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL basic_first_addr: got %h expected 10", mem_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_accept: got %b expected 0", busy); end
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b expected 1", k, out_valid); end
      n_checks++; if (out_data !== exp[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", k, out_data, exp[k]); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b expected 1", k, busy); end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_end: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_once: got %b expected 0", done); end
  endtask

  task automatic test_stall();
    logic [7:0] exp [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    logic [3:0] pat = 4'b1001;
    logic       stalled = 1'b0;
    logic [7:0] prev = '0;
    int hs = 0;
    int dones = 0;
    base_addr = 8'h10; len = 9'd4; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      out_ready = pat[3 - (c % 4)];
      if (stalled) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== prev) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h expected v=1 d=%h", c, out_valid, out_data, prev); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (hs >= 4) begin n_fail++; $display("FAIL stall_extra_word: got %0d handshakes expected 4", hs + 1); end
        else if (out_data !== exp[hs]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", hs, out_data, exp[hs]); end
        hs++;
      end
      stalled = out_valid && !out_ready;
      prev = out_data;
      if (done) dones++;
      tick();
    end
    out_ready = 1'b1;
    n_checks++; if (hs != 4) begin n_fail++; $display("FAIL stall_handshakes: got %0d expected 4", hs); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    base_addr = 8'hFE; len = 9'd4; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp[k]) begin n_fail++; $display("FAIL wrap_data[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp[k]); end
      tick();
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_empty();
    base_addr = 8'h55; len = 9'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b expected 1", done); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_after: got d=%b b=%b v=%b expected 0 0 0", done, busy, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [2] = '{8'hE5, 8'hE4};
    base_addr = 8'h20; len = 9'd8; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h87) begin n_fail++; $display("FAIL rstmid_pre: got v=%b d=%h expected v=1 d=87", out_valid, out_data); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_async: got v=%b b=%b d=%h expected 0 0 00", out_valid, busy, out_data); end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done[%0d]: got d=%b v=%b expected 0 0", c, done, out_valid); end
    end
    base_addr = 8'h40; len = 9'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp[k]) begin n_fail++; $display("FAIL rstmid_new[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp[k]); end
      tick();
    end
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_done: got d=%b v=%b expected 1 0", done, out_valid); end
    tick();
  endtask

  task automatic test_ignore_start();
    logic [7:0] exp [3] = '{8'h95, 8'h94, 8'h97};
    base_addr = 8'h30; len = 9'd3; out_ready = 1'b1; start = 1'b1;
    tick();
    base_addr = 8'h80; len = 9'd5;
    for (int k = 0; k < 3; k++) begin
      start = (k < 2);
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp[k]) begin n_fail++; $display("FAIL ignore_data[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp[k]); end
      tick();
    end
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_done: got d=%b v=%b expected 1 0", done, out_valid); end
    tick();
    n_checks++; if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got d=%b v=%b b=%b expected 0 0 0", done, out_valid, busy); end
  endtask

  task automatic test_full();
    logic [7:0] a;
    int bad = 0;
    base_addr = 8'h80; len = 9'd256; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a = 8'(8'h80 + i);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== (a ^ 8'hA5)) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL full_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, a ^ 8'hA5);
      end
      tick();
    end
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_done: got d=%b v=%b expected 1 0", done, out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    preload();
    test_basic();
    test_stall();
    test_wrap();
    test_empty();
    test_reset_mid();
    test_ignore_start();
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter DWIDTH, default 8, data word width.
REQ-002 Parameter AWIDTH, default 8, memory address width; depth is 2^AWIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 base_addr  input  AWIDTH  first word address, captured with start.
REQ-007 len  input  AWIDTH+1  word count, captured with start; 0 is a legal empty burst.
REQ-008 mem_addr  output  AWIDTH  read address to an asynchronous-read RAM (ASYNC_RAM q port).
REQ-009 mem_q  input  DWIDTH  combinational read data for mem_addr.
REQ-010 out_data  output  DWIDTH  stream data, registered.
REQ-011 out_valid  output  1  stream valid, registered.
REQ-012 out_ready  input  1  stream ready from the consumer.
REQ-013 busy  output  1  high from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse at burst completion.

Function
REQ-015 FSM states: IDLE, STREAM, FINISH; encoding is an implementation choice.
REQ-016 IDLE: start=1 and len>0 -> STREAM; start=1 and len=0 -> FINISH; otherwise stay.
REQ-017 On an accepted start with len>0, mem_addr=base_addr combinationally in that cycle, out_data<=mem_q and out_valid<=1 at the following edge (latency 1 cycle).
REQ-018 A handshake occurs in a cycle where out_valid=1 and out_ready=1.
REQ-019 Sustained out_ready=1 gives one word per cycle with no bubbles.
REQ-020 On a handshake with words remaining, the next word, mem[prev+1], is loaded into out_data in the same edge.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_valid and the word counter hold.
REQ-022 mem_addr presents the address of the next word to load; it holds when no load occurs.
REQ-023 The address increments modulo 2^AWIDTH; e.g. base 0xFE with len 4 reads 0xFE, 0xFF, 0x00, 0x01.
REQ-024 len = 2^AWIDTH reads every location exactly once.
REQ-025 On the handshake of the last word, out_valid<=0 and the state goes to FINISH.
REQ-026 FINISH lasts exactly one cycle with done=1 and busy=0, then the state returns to IDLE.
REQ-027 busy=1 in STREAM only.
REQ-028 start outside IDLE is ignored, with no effect on the current burst.
REQ-029 The block never writes memory; the RAM's we is owned by another agent, and the block assumes no concurrent writes during a burst.

Reset
REQ-030 rst_n low forces immediately, without waiting for a clock edge: state=IDLE, out_valid=0, out_data=0, busy=0, done=0, internal address=0, counter=0.
REQ-031 Reset mid-burst abandons the burst; no done pulse follows.
REQ-032 After rst_n deasserts, the first accepted start behaves as a fresh burst.

Structure
REQ-033 Shared package ram_rd_pkg holds the FSM state type and constants S_IDLE, S_STREAM, S_FINISH.
REQ-034 The block is flat with no sub-module; the testbench instantiates ASYNC_RAM (DWIDTH=8, AWIDTH=8) as the memory model.
REQ-035 Expected size is 120-250 lines of RTL.

Verification
REQ-036 Memory preloaded with mem[i]=i^0xA5; start with base 0x10, len 4, out_ready=1 -> out_valid from cycle+1 for 4 consecutive cycles with data 0xB5, 0xB4, 0xB7, 0xB6, then done pulses once.
REQ-037 Same burst with out_ready toggled 1,0,0,1,... -> data held stable during stalls, no word lost or duplicated, 4 handshakes total.
REQ-038 base 0xFE, len 4 -> words from addresses 0xFE, 0xFF, 0x00, 0x01 in order.
REQ-039 len 0 -> no out_valid; done pulses the cycle after start; busy stays 0.
REQ-040 rst_n pulsed low after 2 of 8 words -> out_valid and busy drop immediately, no done; a new burst with base 0x40, len 2 then runs correctly.
REQ-041 start re-asserted during STREAM with different base_addr/len -> ignored; the original burst completes unchanged.
